// File: rtl/rst_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
package rst_seq_pkg;

  // Sequencer states. RELEASE names the single-edge action of dropping a
  // stage reset; it is folded into the HOLD/GAP exits and never held.
  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
    WAIT_ACK,
    GAP,
    DONE,
    FAULT
  } rst_seq_state_t;

  // Width of the shared timer: must hold the largest of the three limits.
  function automatic int cnt_width(input int hold_cycles, input int stage_gap,
                                   input int ack_timeout);
    int m;
    m = hold_cycles;
    if (stage_gap > m) m = stage_gap;
    if (ack_timeout > m) m = ack_timeout;
    return $clog2(m + 1);
  endfunction

  // Width of a stage index; a single stage still gets one bit.
  function automatic int idx_width(input int num_stages);
    return (num_stages > 1) ? $clog2(num_stages) : 1;
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// Loadable down-counter shared by the hold, gap and acknowledge-timeout phases.
// done is high on the last cycle of a loaded interval, so an interval of L
// loaded at edge T expires (done sampled high) at edge T+L.
module rst_seq_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;

  // Reload on request, otherwise count down and park at zero.
  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (load)
      count_q <= load_val;
    else if (count_q != '0)
      count_q <= count_q - W'(1);
  end

  assign done = (count_q == W'(1));

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: releases NUM_STAGES downstream resets one at a time after a
// hold period, waiting for each stage to acknowledge, retrying after timeouts.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 8,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                soft_rst_req,
  input  logic [NUM_STAGES-1:0]               stage_ok,
  output logic [NUM_STAGES-1:0]               stage_rst,
  output logic                                ready,
  output logic                                busy,
  output logic                                fault,
  output logic [idx_width(NUM_STAGES)-1:0]    fault_stage
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
  localparam int IDX_W = idx_width(NUM_STAGES);

  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(STAGE_GAP);
  localparam logic [CNT_W-1:0] ACK_VAL  = CNT_W'(ACK_TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  rst_seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_inc;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  fault_q, fault_d;
  logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;

  logic                  tmr_load;
  logic [CNT_W-1:0]      tmr_val;
  logic                  tmr_done;

  rst_seq_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign idx_inc = idx_q + IDX_W'(1);

  // Next-state, stage-release and timer-load decisions.
  // NOTE: every signal driven here gets a default first, so no path through
  // the if/case tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    stage_rst_d   = stage_rst_q;
    fault_d       = fault_q;
    fault_stage_d = fault_stage_q;
    tmr_load      = 1'b0;
    tmr_val       = HOLD_VAL;

    if (rst) begin
      // Register values are forced in the flop process; arm the hold here.
      tmr_load = 1'b1;
    end else if (soft_rst_req) begin
      // Restart from scratch; beats a same-edge acknowledge or timeout.
      state_d     = HOLD;
      idx_d       = '0;
      stage_rst_d = '1;
      tmr_load    = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (tmr_done) begin
            stage_rst_d[0] = 1'b0;
            state_d        = WAIT_ACK;
            tmr_load       = 1'b1;
            tmr_val        = ACK_VAL;
          end
        end
        WAIT_ACK: begin
          if (stage_ok[idx_q]) begin
            if (idx_q == LAST_IDX) begin
              state_d = DONE;
            end else begin
              state_d  = GAP;
              tmr_load = 1'b1;
              tmr_val  = GAP_VAL;
            end
          end else if (tmr_done) begin
            state_d       = FAULT;
            stage_rst_d   = '1;
            fault_d       = 1'b1;
            fault_stage_d = idx_q;
          end
        end
        GAP: begin
          if (tmr_done) begin
            idx_d                = idx_inc;
            stage_rst_d[idx_inc] = 1'b0;
            state_d              = WAIT_ACK;
            tmr_load             = 1'b1;
            tmr_val              = ACK_VAL;
          end
        end
        DONE: begin
          // Stages self-monitor once released; later drops are ignored.
        end
        FAULT: begin
          state_d  = HOLD;
          idx_d    = '0;
          tmr_load = 1'b1;
        end
        default: begin
          state_d     = HOLD;
          idx_d       = '0;
          stage_rst_d = '1;
          tmr_load    = 1'b1;
        end
      endcase
    end

    // ready follows one edge after DONE is reached and drops with any exit.
    ready_d = (state_q == DONE) && (state_d == DONE);
    busy_d  = ~ready_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HOLD;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      ready_q       <= 1'b0;
      busy_q        <= 1'b1;
      fault_q       <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      stage_rst_q   <= stage_rst_d;
      ready_q       <= ready_d;
      busy_q        <= busy_d;
      fault_q       <= fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  assign stage_rst   = stage_rst_q;
  assign ready       = ready_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed timing scenarios with literal
// expectations plus randomized stimulus against an edge-count reference model.
module tb_rst_seq;

  localparam int N  = 3;
  localparam int HC = 4;
  localparam int SG = 2;
  localparam int AT = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         soft_rst_req;
  logic [N-1:0] stage_ok;
  logic [N-1:0] stage_rst;
  logic         ready;
  logic         busy;
  logic         fault;
  logic [1:0]   fault_stage;

  rst_seq #(
    .NUM_STAGES  (N),
    .HOLD_CYCLES (HC),
    .STAGE_GAP   (SG),
    .ACK_TIMEOUT (AT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .stage_ok     (stage_ok),
    .stage_rst    (stage_rst),
    .ready        (ready),
    .busy         (busy),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model in terms of absolute edge numbers: how many stages are
  // released, how many acknowledged, and when the last milestone happened.
  int edge_n   = 0;
  int t0       = 0;
  int rel_edge = 0;
  int ack_edge = 0;
  int released = 0;
  int acked    = 0;
  bit m_fault  = 1'b0;
  int m_fstage = 0;
  bit chk_en   = 1'b0;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      released = 0; acked = 0; t0 = edge_n;
      m_fault = 1'b0; m_fstage = 0;
      chk_en = 1'b1;
    end else if (soft_rst_req) begin
      released = 0; acked = 0; t0 = edge_n;
    end else if (released == 0) begin
      if (edge_n - t0 == HC) begin
        released = 1; rel_edge = edge_n;
      end
    end else if (acked < released) begin
      if (stage_ok[acked]) begin
        acked++; ack_edge = edge_n;
      end else if (edge_n - rel_edge == AT) begin
        m_fault = 1'b1; m_fstage = acked;
        released = 0; acked = 0; t0 = edge_n + 1;
      end
    end else if (released < N) begin
      if (edge_n - ack_edge == SG) begin
        released++; rel_edge = edge_n;
      end
    end
  end

  // Compare every cycle on the falling edge once the model is initialised.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [N-1:0] exp_rst;
      logic         exp_ready;
      for (int k = 0; k < N; k++) exp_rst[k] = (k >= released);
      exp_ready = (acked == N) && (edge_n > ack_edge);
      check("stage_rst", 32'(stage_rst), 32'(exp_rst));
      check("ready", 32'(ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(!exp_ready));
      check("fault", 32'(fault), 32'(m_fault));
      check("fault_stage", 32'(fault_stage), 32'(m_fstage));
    end
  end

  // Advance n rising edges and settle 2 time units past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; soft_rst_req = 1'b0; stage_ok = '0;

    // Nominal sequence: releases at edges 4, 7, 10; ready at 12.
    tick(5);
    check("reset_stage_rst", 32'(stage_rst), 32'h7);
    check("reset_busy", 32'(busy), 32'h1);
    rst = 1'b0; stage_ok = 3'b111;
    tick(3);  check("e3_stage_rst", 32'(stage_rst), 32'h7);
    tick(1);  check("e4_stage_rst", 32'(stage_rst), 32'h6);
    tick(3);  check("e7_stage_rst", 32'(stage_rst), 32'h4);
    tick(3);  check("e10_stage_rst", 32'(stage_rst), 32'h0);
    tick(1);  check("e11_ready", 32'(ready), 32'h0);
    tick(1);  check("e12_ready", 32'(ready), 32'h1);
    check("e12_busy", 32'(busy), 32'h0);
    check("e12_fault", 32'(fault), 32'h0);

    // Soft request from DONE repeats the full timing from its edge.
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    check("soft_stage_rst", 32'(stage_rst), 32'h7);
    check("soft_ready", 32'(ready), 32'h0);
    check("soft_busy", 32'(busy), 32'h1);
    tick(4);  check("soft_e4", 32'(stage_rst), 32'h6);
    tick(3);  check("soft_e7", 32'(stage_rst), 32'h4);
    tick(3);  check("soft_e10", 32'(stage_rst), 32'h0);
    tick(2);  check("soft_e12_ready", 32'(ready), 32'h1);

    // Stage 1 never acknowledges: fault at edge 15, then a successful retry.
    rst = 1'b1; tick(1); rst = 1'b0; stage_ok = 3'b101;
    tick(14); check("to_e14_stage_rst", 32'(stage_rst), 32'h4);
    check("to_e14_fault", 32'(fault), 32'h0);
    tick(1);  check("to_e15_fault", 32'(fault), 32'h1);
    check("to_e15_fault_stage", 32'(fault_stage), 32'h1);
    check("to_e15_stage_rst", 32'(stage_rst), 32'h7);
    stage_ok = 3'b111;
    tick(20); check("retry_ready", 32'(ready), 32'h1);
    check("retry_fault_sticky", 32'(fault), 32'h1);

    // rst pulse while in GAP after stage 0 clears everything including fault.
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    tick(5);  check("gap_stage_rst", 32'(stage_rst), 32'h6);
    check("gap_fault_before", 32'(fault), 32'h1);
    rst = 1'b1; tick(1);
    check("gap_rst_stage_rst", 32'(stage_rst), 32'h7);
    check("gap_rst_fault", 32'(fault), 32'h0);
    check("gap_rst_busy", 32'(busy), 32'h1);
    rst = 1'b0;

    // Soft request on the timeout edge of stage 0 (edge 12): no fault.
    stage_ok = 3'b110;
    tick(11); check("st_e11_stage_rst", 32'(stage_rst), 32'h6);
    soft_rst_req = 1'b1; tick(1); soft_rst_req = 1'b0;
    check("st_e12_fault", 32'(fault), 32'h0);
    check("st_e12_stage_rst", 32'(stage_rst), 32'h7);
    tick(4);  check("st_e16_stage_rst", 32'(stage_rst), 32'h6);
    stage_ok = 3'b111;
    tick(12);

    // Late acknowledge of stage 0 with stage 2 already high.
    rst = 1'b1; tick(1); rst = 1'b0; stage_ok = 3'b100;
    tick(8);  stage_ok = 3'b101;
    tick(2);  check("late_e10_stage_rst", 32'(stage_rst), 32'h6);
    tick(1);  check("late_e11_stage_rst", 32'(stage_rst), 32'h4);
    stage_ok = 3'b111;
    tick(10);

    // Randomized stimulus: slowly wandering acks, sparse soft and hard resets.
    for (int i = 0; i < 4000; i++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 5) == 0) stage_ok[k] = ~stage_ok[k];
      soft_rst_req = ($urandom_range(0, 59) == 0);
      rst          = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst = 1'b0; soft_rst_req = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
